// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, frame-length codes and length decode for spi_slave
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  localparam logic [1:0] LEN_8 = 2'd0, LEN_16 = 2'd1, LEN_24 = 2'd2, LEN_32 = 2'd3;
  function automatic logic [5:0] len_bits(input logic [1:0] code);
    return code == LEN_8 ? 6'd8 : code == LEN_16 ? 6'd16 : code == LEN_24 ? 6'd24 : 6'd32;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-flop synchroniser with one-clk rise/fall pulses on the synced level
//   clk, rst (async active-low), d (async input) -> q (synced level), rise, fall (one-clk pulses)
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: CPHA=0 SPI responder, CPOL selectable, MSB first, 8/16/24/32-bit frames
//   clk, rst (async active-low); SPI_SCLK, CS (active low), MOSI in; MISO out
//   CPOL, default_val (MISO idle/fill), transaction_length, tx_data sampled at CS fall
//   rx_data, rx_valid (one-clk pulse), rx_short, busy out
//   SPI_SLAVE_MISO_TRISTATE_EN: when defined, MISO floats unless ACTIVE with CS low
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        CPOL,
  input  logic        default_val,
  input  logic [1:0]  transaction_length,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_short,
  output logic        busy
);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s, mosi_rise, mosi_fall;
  logic unused_mosi_edges;
  // CS chain resets low so a CS already low at reset release never looks like a fresh fall
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(SPI_SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs   (.clk(clk), .rst(rst), .d(CS),       .q(cs_s),   .rise(cs_rise),   .fall(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(MOSI),     .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  assign unused_mosi_edges = ^{mosi_rise, mosi_fall, sclk_s};
  logic lead, trail;
  assign lead  = CPOL ? sclk_fall : sclk_rise;
  assign trail = CPOL ? sclk_rise : sclk_fall;
  state_e      state_q, state_d;
  logic [5:0]  len_q, len_d, cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic        miso_q, miso_d, valid_q, valid_d, short_q, short_d, pend_q, pend_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= 6'd8;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      miso_q    <= 1'b0;
      valid_q   <= 1'b0;
      short_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      miso_q    <= miso_d;
      valid_q   <= valid_d;
      short_q   <= short_d;
      pend_q    <= pend_d;
    end
  // tx word is held MSB-aligned so the bit on the wire is always tx_q[31]
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    miso_d    = miso_q;
    valid_d   = 1'b0;
    short_d   = short_q;
    pend_d    = 1'b0;
    case (state_q)
      IDLE: if (cs_fall || pend_q) begin
        state_d = ACTIVE;
        len_d   = len_bits(transaction_length);
        tx_d    = tx_data << (6'd32 - len_d);
        rx_d    = '0;
        cnt_d   = '0;
        miso_d  = tx_d[31];
      end
      ACTIVE: if (cs_rise) state_d = DONE;
      else begin
        if (lead && cnt_q < len_q) begin
          rx_d  = {rx_q[30:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
        end
        if (trail) begin
          miso_d = cnt_q < len_q ? tx_q[30] : default_val;
          tx_d   = cnt_q < len_q ? tx_q << 1 : tx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        pend_d  = cs_fall;
        if (cnt_q != 6'd0) begin
          rx_data_d = rx_q & (32'hFFFF_FFFF >> (6'd32 - len_q));
          short_d   = cnt_q < len_q;
          valid_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign rx_data  = rx_data_q;
  assign rx_valid = valid_q;
  assign rx_short = short_q;
  assign busy     = state_q != IDLE;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = (state_q == ACTIVE && !cs_s) ? miso_q : 1'bz;
`else
  assign MISO = (state_q == ACTIVE && !cs_s) ? miso_q : default_val;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave acting as a CPHA=0 SPI master
module tb_spi_slave;
  localparam int SS = 2;
  localparam int H  = 8;
  logic        clk = 1'b0, rst, SPI_SCLK, CS, MOSI, CPOL, default_val;
  logic        MISO, rx_valid, rx_short, busy;
  logic [1:0]  transaction_length;
  logic [31:0] tx_data, rx_data, sw;
  int          checks = 0, fails = 0, cnt, lat;
  spi_slave #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .SPI_SCLK(SPI_SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .CPOL(CPOL), .default_val(default_val), .transaction_length(transaction_length),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_short(rx_short), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int n, input logic [31:0] mw, input int len, output logic [31:0] miso_w);
    miso_w = '0;
    @(negedge clk);
    CS   = 1'b0;
    MOSI = len > 0 ? mw[len-1] : 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (H) @(negedge clk);
      SPI_SCLK = ~CPOL;
      miso_w   = {miso_w[30:0], MISO};
      repeat (H) @(negedge clk);
      SPI_SCLK = CPOL;
      MOSI     = (i + 1 < len) ? mw[len-2-i] : 1'b1;
    end
    repeat (H) @(negedge clk);
  endtask
  task automatic finish(output int c, output int l);
    c = 0;
    l = 0;
    @(negedge clk);
    CS = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        c++;
        if (l == 0) l = i;
      end
    end
  endtask
  initial begin
    rst = 1'b0; SPI_SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; CPOL = 1'b0; default_val = 1'b0;
    transaction_length = 2'b00; tx_data = '0;
    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
    chk("rst_rx_short", {31'b0, rx_short}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
`ifndef SPI_SLAVE_MISO_TRISTATE_EN
    chk("rst_miso", {31'b0, MISO}, 32'h0);
`endif
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tx_data = 32'hA5; transaction_length = 2'b00;
    xfer(8, 32'h3C, 8, sw);
    chk("t1_miso", sw, 32'hA5);
    finish(cnt, lat);
    chk("t1_rx_data", rx_data, 32'h3C);
    chk("t1_valid_cnt", cnt, 1);
    chk("t1_latency", lat, SS + 2);
    chk("t1_rx_short", {31'b0, rx_short}, 32'h0);
    chk("t1_busy_after", {31'b0, busy}, 32'h0);
    CPOL = 1'b1; SPI_SCLK = 1'b1;
    repeat (6) @(negedge clk);
    tx_data = 32'hDEADBEEF; transaction_length = 2'b11;
    xfer(32, 32'h12345678, 32, sw);
    chk("t2_miso", sw, 32'hDEADBEEF);
    finish(cnt, lat);
    chk("t2_rx_data", rx_data, 32'h12345678);
    chk("t2_valid_cnt", cnt, 1);
    chk("t2_rx_short", {31'b0, rx_short}, 32'h0);
    CPOL = 1'b0; SPI_SCLK = 1'b0;
    repeat (6) @(negedge clk);
    tx_data = 32'h0; transaction_length = 2'b01;
    xfer(5, 32'hF800, 16, sw);
    finish(cnt, lat);
    chk("t3_valid_cnt", cnt, 1);
    chk("t3_rx_data", rx_data, 32'h1F);
    chk("t3_rx_short", {31'b0, rx_short}, 32'h1);
    default_val = 1'b1; tx_data = 32'h5A; transaction_length = 2'b00;
    xfer(12, 32'h81, 8, sw);
    chk("t4_miso_fill", sw, 32'h5AF);
    finish(cnt, lat);
    chk("t4_rx_data", rx_data, 32'h81);
    chk("t4_rx_short", {31'b0, rx_short}, 32'h0);
    chk("t4_valid_cnt", cnt, 1);
`ifndef SPI_SLAVE_MISO_TRISTATE_EN
    chk("t4_miso_idle", {31'b0, MISO}, 32'h1);
`endif
    default_val = 1'b0;
    xfer(3, 32'hFF, 8, sw);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rx_data_rst", rx_data, 32'h0);
    chk("t5_busy_rst", {31'b0, busy}, 32'h0);
    chk("t5_valid_rst", {31'b0, rx_valid}, 32'h0);
    chk("t5_short_rst", {31'b0, rx_short}, 32'h0);
    rst = 1'b1;
    xfer(5, 32'hFF, 8, sw);
    chk("t5_busy_cs_low", {31'b0, busy}, 32'h0);
    finish(cnt, lat);
    chk("t5_no_valid", cnt, 0);
    chk("t5_rx_data_hold", rx_data, 32'h0);
    tx_data = 32'hC3;
    xfer(8, 32'h96, 8, sw);
    chk("t5_new_miso", sw, 32'hC3);
    finish(cnt, lat);
    chk("t5_new_rx_data", rx_data, 32'h96);
    chk("t5_new_valid_cnt", cnt, 1);
    tx_data = 32'h80;
    @(negedge clk);
    CS = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_busy_pulse", {31'b0, busy}, 32'h1);
    chk("t6_miso_active", {31'b0, MISO}, 32'h1);
    finish(cnt, lat);
    chk("t6_no_valid", cnt, 0);
    chk("t6_rx_data_hold", rx_data, 32'h96);
    chk("t6_busy_after", {31'b0, busy}, 32'h0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    checks++;
    assert (MISO === 1'bz) else begin
      fails++;
      $error("FAIL t6_miso_idle_z: got %b expected z", MISO);
    end
`else
    chk("t6_miso_idle", {31'b0, MISO}, 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
